// File: rtl/calc_pkg.sv
// Shared state codes and ALU operation encodings for the keypad calculator sequencer.
// Constants only; no logic, no latency, no flow control.
package calc_pkg;

  typedef enum logic [2:0] {
    S_WAIT_A = 3'd0,
    S_REL_A  = 3'd1,
    S_WAIT_B = 3'd2,
    S_REL_B  = 3'd3,
    S_EXEC   = 3'd4,
    S_SHOW   = 3'd5
  } state_e;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/key_press_detect.sv
// Edge detector for keypad codes: PRESS is the zero-to-nonzero transition, same cycle as KEY_IN.
// Zero latency, no backpressure; held resets to 1 so a key held through reset must be released first.
module key_press_detect #(
  parameter int W = 3
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] KEY_IN,
  output logic         PRESS,
  output logic         RELEASE
);

  logic held_q;
  logic held_d;

  always_comb begin
    held_d = (KEY_IN != '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      held_q <= 1'b1;
    end else begin
      held_q <= held_d;
    end
  end

  // A code change without an intervening zero keeps held_q set, so it is not a press.
  assign PRESS   = held_d && !held_q;
  assign RELEASE = !held_d;

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: turns press/release events into one-cycle A/B/O load strobes.
// LD_A/LD_B same cycle as the press, LD_O one cycle after B release; no backpressure, CLR discards the current cycle.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] KEY_IN,
  input  logic         KEY_OP,
  input  logic         CLR,
  input  logic         CARRY,
  output logic [W-1:0] OPND,
  output logic         LD_A,
  output logic         LD_B,
  output logic         LD_O,
  output logic         ALU_SEL,
  output logic         OVF,
  output logic         DONE,
  output logic [2:0]   STATE
);

  state_e state_q;
  state_e state_d;
  logic   alu_sel_q;
  logic   alu_sel_d;
  logic   ovf_q;
  logic   ovf_d;
  logic   ld_a;
  logic   ld_b;
  logic   press;
  logic   release_key;

  key_press_detect #(
    .W (W)
  ) u_key (
    .CLK     (CLK),
    .RST     (RST),
    .KEY_IN  (KEY_IN),
    .PRESS   (press),
    .RELEASE (release_key)
  );

  always_comb begin
    state_d   = state_q;
    alu_sel_d = alu_sel_q;
    ovf_d     = ovf_q;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    case (state_q)
      S_WAIT_A: begin
        if (press) begin
          ld_a    = 1'b1;
          state_d = S_REL_A;
        end
      end
      S_REL_A: begin
        if (release_key) state_d = S_WAIT_B;
      end
      S_WAIT_B: begin
        if (press) begin
          ld_b      = 1'b1;
          alu_sel_d = KEY_OP ? ALU_SUB : ALU_ADD;
          state_d   = S_REL_B;
        end
      end
      S_REL_B: begin
        if (release_key) state_d = S_EXEC;
      end
      S_EXEC: begin
        ovf_d   = CARRY;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (press) begin
          ld_a    = 1'b1;
          ovf_d   = 1'b0;
          state_d = S_REL_A;
        end
      end
      default: state_d = S_WAIT_A;
    endcase
    // Clear wins over any press or release seen in the same cycle.
    if (CLR) begin
      state_d   = S_WAIT_A;
      alu_sel_d = ALU_ADD;
      ovf_d     = 1'b0;
      ld_a      = 1'b0;
      ld_b      = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_WAIT_A;
      alu_sel_q <= ALU_ADD;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_sel_q <= alu_sel_d;
      ovf_q     <= ovf_d;
    end
  end

  assign OPND    = KEY_IN;
  assign LD_A    = ld_a && !RST;
  assign LD_B    = ld_b && !RST;
  assign LD_O    = (state_q == S_EXEC) && !CLR && !RST;
  assign DONE    = (state_q == S_SHOW);
  assign ALU_SEL = alu_sel_q;
  assign OVF     = ovf_q;
  assign STATE   = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: a cycle model of the sequencer plus a datapath model,
// checked every cycle, with hand-computed literal expectations at the key points.
module tb_calc_sequencer;
  import calc_pkg::*;

  logic       CLK;
  logic       RST;
  logic [2:0] KEY_IN;
  logic       KEY_OP;
  logic       CLR;
  logic       CARRY;
  logic [2:0] OPND;
  logic       LD_A;
  logic       LD_B;
  logic       LD_O;
  logic       ALU_SEL;
  logic       OVF;
  logic       DONE;
  logic [2:0] STATE;

  calc_sequencer #(.W(3)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .KEY_IN  (KEY_IN),
    .KEY_OP  (KEY_OP),
    .CLR     (CLR),
    .CARRY   (CARRY),
    .OPND    (OPND),
    .LD_A    (LD_A),
    .LD_B    (LD_B),
    .LD_O    (LD_O),
    .ALU_SEL (ALU_SEL),
    .OVF     (OVF),
    .DONE    (DONE),
    .STATE   (STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: phase 0..5 follows the calculation steps, anything else is illegal.
  int         m_state = 0;
  bit         m_held  = 1'b1;
  bit         m_sel   = 1'b0;
  bit         m_ovf   = 1'b0;
  bit         m_valid = 1'b0;
  bit         force_six = 1'b0;
  logic [2:0] m_a = 3'd0;
  logic [2:0] m_b = 3'd0;
  logic [2:0] m_o = 3'd0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0d, expected %0d", nm, cyc, act, exp_v);
    end
  endtask

  task automatic sample();
    int  eff;
    bit  pr;
    bit  live;
    @(negedge CLK);
    if (m_valid) begin
      eff  = force_six ? 6 : m_state;
      pr   = (KEY_IN != 3'd0) && !m_held;
      live = !RST && !CLR;
      chk("ld_a",    int'(LD_A),    int'(live && pr && (eff == 0 || eff == 5)));
      chk("ld_b",    int'(LD_B),    int'(live && pr && eff == 2));
      chk("ld_o",    int'(LD_O),    int'(live && eff == 4));
      chk("done",    int'(DONE),    int'(eff == 5));
      chk("alu_sel", int'(ALU_SEL), int'(m_sel));
      chk("ovf",     int'(OVF),     int'(m_ovf));
      chk("opnd",    int'(OPND),    int'(KEY_IN));
      chk("state",   int'(STATE),   eff);
    end
  endtask

  task automatic advance();
    int eff;
    bit pr;
    eff = force_six ? 6 : m_state;
    pr  = (KEY_IN != 3'd0) && !m_held;
    if (RST) begin
      m_state = 0;
      m_held  = 1'b1;
      m_sel   = 1'b0;
      m_ovf   = 1'b0;
      m_valid = 1'b1;
    end else begin
      if (CLR) begin
        m_state = 0;
        m_sel   = 1'b0;
        m_ovf   = 1'b0;
      end else begin
        case (eff)
          0: if (pr) begin m_a = KEY_IN; m_state = 1; end
          1: if (KEY_IN == 3'd0) m_state = 2;
          2: if (pr) begin m_b = KEY_IN; m_sel = KEY_OP; m_state = 3; end
          3: if (KEY_IN == 3'd0) m_state = 4;
          4: begin
            m_o     = m_sel ? (m_a - m_b) : (m_a + m_b);
            m_ovf   = CARRY;
            m_state = 5;
          end
          5: if (pr) begin m_a = KEY_IN; m_ovf = 1'b0; m_state = 1; end
          default: m_state = 0;
        endcase
      end
      m_held = (KEY_IN != 3'd0);
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  // Full calculation a (op) b; leaves the sequencer showing the result.
  task automatic calc(input logic [2:0] a, input logic [2:0] b, input logic op, input logic c);
    KEY_IN = a;    tick(1);
    KEY_IN = 3'd0; tick(1);
    KEY_IN = b; KEY_OP = op; tick(1);
    KEY_IN = 3'd0; CARRY = c; tick(1);
    tick(1);
    CARRY = 1'b0; KEY_OP = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; KEY_IN = 3'd0; KEY_OP = 1'b0; CLR = 1'b0; CARRY = 1'b0;
    tick(3);
    RST = 1'b0;
    sample();
    chk("rst_state", int'(STATE), 0);
    chk("rst_done",  int'(DONE), 0);
    chk("rst_ovf",   int'(OVF), 0);
    chk("rst_sel",   int'(ALU_SEL), 0);
    advance();

    // 2 + 4, no carry
    KEY_IN = 3'd2;
    sample(); chk("t1_lda", int'(LD_A), 1); chk("t1_opnd_a", int'(OPND), 2); advance();
    tick(1);
    KEY_IN = 3'd0; tick(1);
    KEY_IN = 3'd4;
    sample(); chk("t1_ldb", int'(LD_B), 1); chk("t1_opnd_b", int'(OPND), 4); advance();
    KEY_IN = 3'd0;
    sample(); chk("t1_sel", int'(ALU_SEL), 0); chk("t1_ldo_early", int'(LD_O), 0); advance();
    sample(); chk("t1_ldo", int'(LD_O), 1); advance();
    sample();
    chk("t1_done", int'(DONE), 1);
    chk("t1_ovf",  int'(OVF), 0);
    chk("t1_o",    int'(m_o), 6);
    advance();

    // 5 + 4 overflows
    calc(3'd5, 3'd4, 1'b0, 1'b1);
    sample();
    chk("t2_ovf", int'(OVF), 1); chk("t2_done", int'(DONE), 1); chk("t2_o", int'(m_o), 1);
    advance();
    KEY_IN = 3'd1;
    sample(); chk("t2_lda", int'(LD_A), 1); chk("t2_opnd", int'(OPND), 1); advance();
    sample(); chk("t2_ovf_clr", int'(OVF), 0); chk("t2_done_clr", int'(DONE), 0); advance();
    KEY_IN = 3'd0; tick(1);
    CLR = 1'b1; tick(1);
    CLR = 1'b0;

    // 3 - 5 borrows
    calc(3'd3, 3'd5, 1'b1, 1'b1);
    sample();
    chk("t3_sel", int'(ALU_SEL), 1); chk("t3_ovf", int'(OVF), 1);
    chk("t3_state", int'(STATE), 5); chk("t3_o", int'(m_o), 6);
    advance();

    // key held through reset, then a 2->4 change without release
    RST = 1'b1; KEY_IN = 3'd6; tick(2);
    RST = 1'b0;
    sample(); chk("t4_held_lda", int'(LD_A), 0); advance();
    tick(2);
    KEY_IN = 3'd0; tick(1);
    KEY_IN = 3'd6;
    sample(); chk("t4_lda", int'(LD_A), 1); advance();
    KEY_IN = 3'd0; tick(1);
    KEY_IN = 3'd2;
    sample(); chk("t4_ldb", int'(LD_B), 1); advance();
    KEY_IN = 3'd4;
    sample(); chk("t4_no_ldb", int'(LD_B), 0); advance();
    tick(1);
    KEY_IN = 3'd0; tick(2);
    sample(); chk("t4_show", int'(STATE), 5); advance();

    // clear in REL_B
    KEY_IN = 3'd1; tick(1);
    KEY_IN = 3'd0; tick(1);
    KEY_IN = 3'd2; KEY_OP = 1'b1; tick(1);
    KEY_IN = 3'd0; KEY_OP = 1'b0; CLR = 1'b1;
    sample(); chk("t5_ldb", int'(LD_B), 0); chk("t5_ldo", int'(LD_O), 0); advance();
    CLR = 1'b0;
    sample();
    chk("t5_state", int'(STATE), 0); chk("t5_ldo2", int'(LD_O), 0);
    chk("t5_sel", int'(ALU_SEL), 0); chk("t5_ovf", int'(OVF), 0);
    advance();

    // clear coincident with a B press
    KEY_IN = 3'd3; tick(1);
    KEY_IN = 3'd0; tick(1);
    KEY_IN = 3'd5; KEY_OP = 1'b1; CLR = 1'b1;
    sample(); chk("t5b_ldb", int'(LD_B), 0); advance();
    CLR = 1'b0;
    sample();
    chk("t5b_state", int'(STATE), 0); chk("t5b_sel", int'(ALU_SEL), 0);
    chk("t5b_lda", int'(LD_A), 0);
    advance();
    KEY_IN = 3'd0; KEY_OP = 1'b0; tick(1);

    // illegal state code recovers with no strobes
    force_six = 1'b1;
    force dut.state_q = state_e'(3'd6);
    KEY_IN = 3'd3;
    sample(); chk("t6_state6", int'(STATE), 6); chk("t6_lda", int'(LD_A), 0);
    release dut.state_q;
    advance();
    force_six = 1'b0;
    sample(); chk("t6_state0", int'(STATE), 0); chk("t6_lda2", int'(LD_A), 0); advance();
    KEY_IN = 3'd0; tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
